// File: rtl/img_feeder_pkg.sv
// Shared types and constants for the image pixel feeder: frame/handshake
// state encodings, pixel geometry and the BGR reorder helper.
package img_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } frame_state_t;

  typedef enum logic {
    H_IDLE    = 1'b0,
    H_PRESENT = 1'b1
  } hs_state_t;

  localparam int PIX_W         = 24;
  localparam int BYTES_PER_PIX = 4;

  function automatic logic [PIX_W-1:0] bgr_swap(input logic [PIX_W-1:0] p);
    return {p[7:0], p[15:8], p[23:16]};
  endfunction

endpackage

// File: rtl/img_pixel_feeder_pix_fifo.sv
// Small synchronous FIFO (register array) with async active-low reset and a
// synchronous flush that empties it regardless of push/pop.
module pix_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push && !flush) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && full && !flush));

endmodule

// File: rtl/img_pixel_feeder.sv
// Avalon-MM frame fetcher feeding pixels to a four-phase get_next_pix/pix_rdy
// reader. Define FEEDER_BGR_SWAP_EN to reorder BGR-stored words into RGB.
module img_pixel_feeder
  import img_feeder_pkg::*;
#(
  parameter int          IMG_W      = 320,
  parameter int          IMG_H      = 240,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_rdy,
  input  logic              get_next_pix,
  output logic              pix_rdy,
  output logic [PIX_W-1:0]  pixel_data,
  output logic              img_done,
  output logic [31:0]       avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int OCW   = $clog2(FIFO_DEPTH + 1);
  localparam int LVW   = OCW + 1;
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
  localparam logic [LVW-1:0]   DEPTH_C = LVW'(FIFO_DEPTH);

  frame_state_t     r_state, w_state_next;
  hs_state_t        r_hs, w_hs_next;
  logic             r_cpu_rdy_d;
  logic             r_arm;
  logic [31:0]      r_addr;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_serve_cnt;
  logic [OCW-1:0]   r_outst, w_outst_next;
  logic [PIX_W-1:0] r_pix;

  logic             w_rise, w_start, w_active, w_accept, w_ret;
  logic             w_push, w_pop, w_served, w_avm_read;
  logic [LVW-1:0]   w_level;
  logic [PIX_W-1:0] w_push_data, w_fifo_head;
  logic             w_fifo_full, w_fifo_empty;
  logic [OCW-1:0]   w_fifo_count;
  logic             w_unused;

  assign w_rise   = cpu_rdy && !r_cpu_rdy_d;
  // A start edge seen while stale reads are still in flight is remembered
  // (r_arm) and taken once they have all drained.
  assign w_start  = (r_state == IDLE) && cpu_rdy && (w_rise || r_arm) && (r_outst == '0);
  assign w_active = ((r_state == FETCH) || (r_state == DRAIN)) && cpu_rdy;

  assign w_level    = LVW'(r_outst) + LVW'(w_fifo_count);
  assign w_avm_read = (r_state == FETCH) && (r_issue_cnt != TOTAL_C) && (w_level < DEPTH_C);
  assign w_accept   = w_avm_read && !avm_waitrequest;
  assign w_ret      = avm_readdatavalid && (r_outst != '0);

  assign w_push   = avm_readdatavalid && ((r_state == FETCH) || (r_state == DRAIN));
  assign w_pop    = w_active && (r_hs == H_IDLE) && get_next_pix && !w_fifo_empty
                    && (r_serve_cnt != TOTAL_C);
  assign w_served = w_active && (r_hs == H_PRESENT) && !get_next_pix;

`ifdef FEEDER_BGR_SWAP_EN
  assign w_push_data = bgr_swap(avm_readdata[PIX_W-1:0]);
`else
  assign w_push_data = avm_readdata[PIX_W-1:0];
`endif

  assign w_unused = &{1'b0, avm_readdata[31:PIX_W], w_fifo_full};

  pix_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (r_state == IDLE),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_fifo_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = FETCH;
      FETCH:   if (!cpu_rdy) w_state_next = IDLE;
               else if (r_issue_cnt == TOTAL_C) w_state_next = DRAIN;
      DRAIN:   if (!cpu_rdy) w_state_next = IDLE;
               else if ((r_serve_cnt == TOTAL_C) && (r_hs == H_IDLE)) w_state_next = DONE;
      DONE:    if (!cpu_rdy) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_hs_next = r_hs;
    if (!w_active) begin
      w_hs_next = H_IDLE;
    end else begin
      case (r_hs)
        H_IDLE:    if (w_pop) w_hs_next = H_PRESENT;
        H_PRESENT: if (!get_next_pix) w_hs_next = H_IDLE;
        default:   w_hs_next = H_IDLE;
      endcase
    end
  end

  // Outstanding keeps tracking returns even in IDLE so aborted reads drain.
  always_comb begin
    w_outst_next = r_outst;
    if (w_accept && !w_ret)      w_outst_next = r_outst + OCW'(1);
    else if (!w_accept && w_ret) w_outst_next = r_outst - OCW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_hs        <= H_IDLE;
      r_cpu_rdy_d <= 1'b0;
      r_arm       <= 1'b0;
      r_addr      <= BASE_ADDR;
      r_issue_cnt <= '0;
      r_serve_cnt <= '0;
      r_outst     <= '0;
      r_pix       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_hs        <= w_hs_next;
      r_cpu_rdy_d <= cpu_rdy;
      r_arm       <= (r_state == IDLE) && cpu_rdy && (r_arm || w_rise) && !w_start;
      r_outst     <= w_outst_next;
      if (w_start) begin
        r_addr      <= BASE_ADDR;
        r_issue_cnt <= '0;
      end else if (w_accept) begin
        r_addr      <= r_addr + 32'(BYTES_PER_PIX);
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      end
      if (w_start)       r_serve_cnt <= '0;
      else if (w_served) r_serve_cnt <= r_serve_cnt + CNT_W'(1);
      if (w_pop) r_pix <= w_fifo_head;
    end
  end

  assign pix_rdy     = (r_hs == H_PRESENT);
  assign pixel_data  = r_pix;
  assign img_done    = (r_state == DONE);
  assign avm_address = r_addr;
  assign avm_read    = w_avm_read;

endmodule
